// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control FSM for a multi-cycle RV32I-subset core. Steps each instruction
//   through FETCH / DECODE / EXECUTE / MEM / WB over one shared ALU and one
//   unified instruction/data memory.
//   Memory accesses use a mem_req/mem_ready handshake. A wait counter aborts
//   an access that stalls for too long. A counter tracks retired instructions.
//
// Parameters
//   MEM_TIMEOUT  wait cycles allowed per memory access before abort (0 = never)
//   TMO_W        wait counter width, must be able to hold MEM_TIMEOUT
//   CNT_W        retired-instruction counter width
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   opc, f3             latched IR[6:0] and IR[14:12]
//   zero, neg, carry    ALU flags for A-B (carry=1 means no borrow)
//   mem_ready           memory finishes the current access this cycle
//   mem_req, adr_src    memory request, address select (0 PC, 1 ALUOut)
//   mem_write           store strobe
//   ir_write, pc_write  IR/oldPC latch enable, PC load enable
//   reg_write           register file write enable
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   imm_src, result_src immediate format select, result bus select
//   illegal             one-cycle pulse for an unknown opcode
//   timeout_err         one-cycle pulse when a memory access is aborted
//   instret             retired instruction count (wraps)
//
// Build option
//   BRANCH_UNSIGNED_EN  adds BLTU/BGEU decoding using the carry flag.
//                       Without it, f3=110/111 branches are never taken.

module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opc,
  input  logic [2:0]       f3,
  input  logic             zero,
  input  logic             neg,
  input  logic             carry,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             adr_src,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic             timeout_err,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC_R,
    S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR_ADR, S_JUMP, S_LUI, S_ILLEGAL
  } state_t;

  state_t           state, state_next;
  logic [TMO_W-1:0] wait_cnt;
  logic             retire;
  logic             in_mem_state;
  logic             tmo_hit;
  logic             branch_taken;

  // State register, wait counter and retire counter.
  // The wait counter restarts whenever the FSM moves to another state. It
  // also restarts after a timeout, because a FETCH abort stays in FETCH and
  // the retried fetch needs a fresh wait budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state <= state_next;
      if (timeout_err || (state_next != state))
        wait_cnt <= '0;
      else if (in_mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        instret <= instret + 1'b1;
    end
  end

  // Branch condition decode from funct3 and the ALU flags of rs1-rs2.
  // Unsigned compares depend on the build option. When the option is off,
  // carry is ANDed with zero, so those branches are never taken.
  always_comb begin
    branch_taken = 1'b0;
    case (f3)
      3'b000:  branch_taken = zero;
      3'b001:  branch_taken = ~zero;
      3'b100:  branch_taken = neg;
      3'b101:  branch_taken = ~neg | zero;
`ifdef BRANCH_UNSIGNED_EN
      3'b110:  branch_taken = ~carry;
      3'b111:  branch_taken = carry;
`else
      3'b110,
      3'b111:  branch_taken = carry & 1'b0;
`endif
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state and output decode.
  // Every output defaults to 0. Each state raises only what it uses.
  // A memory state that is still waiting when its budget runs out aborts:
  // it drops every strobe, pulses timeout_err and returns to FETCH.
  // If mem_ready arrives in that same cycle, the access completes instead.
  // All write strobes and pulses are masked while reset is held.
  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    imm_src      = 3'b000;
    result_src   = 2'b00;
    illegal      = 1'b0;
    timeout_err  = 1'b0;
    retire       = 1'b0;
    in_mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    tmo_hit      = (MEM_TIMEOUT != 0) && in_mem_state && !mem_ready &&
                   (wait_cnt == TMO_W'(MEM_TIMEOUT));

    case (state)
      S_FETCH: begin
        if (mem_ready) begin
          mem_req    = 1'b1;
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          state_next = S_DECODE;
        end else if (tmo_hit) begin
          timeout_err = 1'b1;
          state_next  = S_FETCH;
        end else begin
          mem_req = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opc == OP_JAL) ? 3'b100 : 3'b010;
        case (opc)
          OP_LW, OP_SW: state_next = S_MEM_ADR;
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_B:         state_next = S_BRANCH;
          OP_JAL:       state_next = S_JUMP;
          OP_JALR:      state_next = S_JALR_ADR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (opc == OP_SW) ? 3'b001 : 3'b000;
        state_next = (opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        if (tmo_hit) begin
          timeout_err = 1'b1;
          state_next  = S_FETCH;
        end else begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_next = S_MEM_WB;
        end
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        if (tmo_hit) begin
          timeout_err = 1'b1;
          state_next  = S_FETCH;
        end else begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
      end
      S_EXEC_R: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b10;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = 2'b11;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = branch_taken;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JALR_ADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        state_next = S_JUMP;
      end
      S_JUMP: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_ALU_WB;
      end
      S_LUI: begin
        imm_src    = 3'b011;
        result_src = 2'b11;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    if (rst) begin
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      illegal     = 1'b0;
      timeout_err = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed testbench for multicycle_controller with default parameters
//   (MEM_TIMEOUT=15, TMO_W=4, CNT_W=32).
//   Inputs change 1 time unit after a rising edge. Outputs are sampled one
//   time unit later, well away from the next edge.
//   The unsigned-branch expectation follows BRANCH_UNSIGNED_EN.

module tb_multicycle_controller;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        zero, neg, carry, mem_ready;
  logic        mem_req, adr_src, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]  imm_src;
  logic        illegal, timeout_err;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(
    .MEM_TIMEOUT(15),
    .TMO_W      (4),
    .CNT_W      (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opc        (opc),
    .f3         (f3),
    .zero       (zero),
    .neg        (neg),
    .carry      (carry),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .adr_src    (adr_src),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .result_src (result_src),
    .illegal    (illegal),
    .timeout_err(timeout_err),
    .instret    (instret)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Drive one set of inputs, then let the combinational outputs settle.
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f,
                               input logic z, input logic n, input logic c,
                               input logic rdy);
    opc       = o;
    f3        = f;
    zero      = z;
    neg       = n;
    carry     = c;
    mem_ready = rdy;
    #1;
  endtask

  // Compare one observed value with its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence. instret grows by one for each instruction retired.
  initial begin
    logic bltu_exp;
`ifdef BRANCH_UNSIGNED_EN
    bltu_exp = 1'b1;
`else
    bltu_exp = 1'b0;
`endif

    rst = 1'b1;
    applyStimulus(7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd1);
    checkOutput("rst_adr_src", 32'(adr_src), 32'd0);
    checkOutput("rst_ir_write", 32'(ir_write), 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    step();
    step();
    rst = 1'b0;

    // LW up to MEM_RD, then reset while the access is pending.
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("fetch_ir_write", 32'(ir_write), 32'd1);
    checkOutput("fetch_pc_write", 32'(pc_write), 32'd1);
    checkOutput("fetch_alu_src_b", 32'(alu_src_b), 32'd2);
    checkOutput("fetch_result_src", 32'(result_src), 32'd2);
    step();
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("dec_alu_src_a", 32'(alu_src_a), 32'd1);
    checkOutput("dec_imm_src", 32'(imm_src), 32'd2);
    step();
    checkOutput("madr_alu_src_a", 32'(alu_src_a), 32'd2);
    checkOutput("madr_imm_src_lw", 32'(imm_src), 32'd0);
    step();
    checkOutput("mrd_mem_req", 32'(mem_req), 32'd1);
    checkOutput("mrd_adr_src", 32'(adr_src), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rstrd_mem_req", 32'(mem_req), 32'd1);
    checkOutput("rstrd_adr_src", 32'(adr_src), 32'd0);
    checkOutput("rstrd_reg_write", 32'(reg_write), 32'd0);
    step();
    rst = 1'b0;
    #1;
    checkOutput("rel_instret", instret, 32'd0);
    checkOutput("rel_mem_req", 32'(mem_req), 32'd1);

    // ADDI: four cycles, write-back in cycle 4.
    applyStimulus(OP_I, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("addi_c1_ir_write", 32'(ir_write), 32'd1);
    step();
    step();
    checkOutput("addi_c3_alu_op", 32'(alu_op), 32'd3);
    checkOutput("addi_c3_reg_write", 32'(reg_write), 32'd0);
    step();
    checkOutput("addi_c4_reg_write", 32'(reg_write), 32'd1);
    checkOutput("addi_c4_result_src", 32'(result_src), 32'd0);
    step();
    checkOutput("addi_instret", instret, 32'd1);
    checkOutput("addi_back_fetch", 32'(ir_write), 32'd1);

    // LW: three wait cycles in MEM_RD, then completion.
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("lw_wait_mem_req", 32'(mem_req), 32'd1);
      step();
    end
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("lw_rdy_mem_req", 32'(mem_req), 32'd1);
    checkOutput("lw_rdy_adr_src", 32'(adr_src), 32'd1);
    step();
    checkOutput("lw_wb_result_src", 32'(result_src), 32'd1);
    checkOutput("lw_wb_reg_write", 32'(reg_write), 32'd1);
    checkOutput("lw_wb_mem_req", 32'(mem_req), 32'd0);
    step();
    checkOutput("lw_instret", instret, 32'd2);

    // Branches: BEQ zero=1 taken, BNE zero=1, BGE neg=1, BLT neg=1.
    applyStimulus(OP_B, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("beq_dec_imm_src", 32'(imm_src), 32'd2);
    step();
    checkOutput("beq_pc_write", 32'(pc_write), 32'd1);
    checkOutput("beq_alu_op", 32'(alu_op), 32'd1);
    step();
    checkOutput("beq_instret", instret, 32'd3);
    applyStimulus(OP_B, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("bne_pc_write", 32'(pc_write), 32'd0);
    step();
    checkOutput("bne_instret", instret, 32'd4);
    applyStimulus(OP_B, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    checkOutput("bge_pc_write", 32'(pc_write), 32'd0);
    step();
    applyStimulus(OP_B, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1);
    step();
    step();
    checkOutput("blt_pc_write", 32'(pc_write), 32'd1);
    step();
    checkOutput("blt_instret", instret, 32'd6);

    // JAL: DECODE -> JUMP -> ALU_WB.
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("jal_dec_imm_src", 32'(imm_src), 32'd4);
    step();
    checkOutput("jal_pc_write", 32'(pc_write), 32'd1);
    checkOutput("jal_alu_src_a", 32'(alu_src_a), 32'd1);
    checkOutput("jal_alu_src_b", 32'(alu_src_b), 32'd2);
    step();
    checkOutput("jal_wb_reg_write", 32'(reg_write), 32'd1);
    step();
    checkOutput("jal_instret", instret, 32'd7);

    // SW with mem_ready never asserted: abort after 15 wait cycles.
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("sw_madr_imm_src", 32'(imm_src), 32'd1);
    step();
    for (int i = 0; i < 15; i++) begin
      applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("sw_wait_mem_write", 32'(mem_write), 32'd1);
      checkOutput("sw_wait_timeout_err", 32'(timeout_err), 32'd0);
      step();
    end
    checkOutput("sw_tmo_timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("sw_tmo_mem_write", 32'(mem_write), 32'd0);
    step();
    checkOutput("sw_after_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("sw_after_mem_req", 32'(mem_req), 32'd1);
    checkOutput("sw_instret", instret, 32'd7);

    // FETCH timeout: the FSM stays in FETCH and retries.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
    end
    checkOutput("ftmo_timeout_err", 32'(timeout_err), 32'd1);
    checkOutput("ftmo_ir_write", 32'(ir_write), 32'd0);
    step();
    checkOutput("ftmo_retry_timeout_err", 32'(timeout_err), 32'd0);
    checkOutput("ftmo_retry_adr_src", 32'(adr_src), 32'd0);
    step();
    for (int i = 0; i < 14; i++) begin
      step();
    end

    // Wait count is now 15. mem_ready wins over timeout, then illegal opcode.
    applyStimulus(OP_BAD, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("race_ir_write", 32'(ir_write), 32'd1);
    checkOutput("race_timeout_err", 32'(timeout_err), 32'd0);
    step();
    step();
    checkOutput("ill_illegal", 32'(illegal), 32'd1);
    checkOutput("ill_reg_write", 32'(reg_write), 32'd0);
    checkOutput("ill_pc_write", 32'(pc_write), 32'd0);
    step();
    checkOutput("ill_pulse_end", 32'(illegal), 32'd0);
    checkOutput("ill_instret", instret, 32'd7);

    // BLTU with carry=0: taken only when unsigned branches are built in.
    applyStimulus(OP_B, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    checkOutput("bltu_pc_write", 32'(pc_write), 32'(bltu_exp));
    step();
    checkOutput("bltu_instret", instret, 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
